vliw_scoreboard: RTL
====================

VLIW_SCOREBOARD -- requirements
Module: vliw_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, issue slots per bundle (R slot = 0, S slot = 1).
REQ-002 SHALL have parameter REG_AW, default 3, register address width.
REQ-003 SHALL have parameter DEPTH, default 3, tracked stages after issue (0=EX, 1=MEM, DEPTH-1=WB).
REQ-004 SHALL have parameter LOAD_READY, default 1, first stage index at which load data is forwardable.
REQ-005 SHALL have ports clk input 1, the single clock, and reset input 1, asynchronous active-low reset.
REQ-006 SHALL have port issue_valid input 1, bundle present.
REQ-007 SHALL have ports src_a, src_b input NUM_SLOTS*REG_AW, per-slot source registers.
REQ-008 SHALL have port dst input NUM_SLOTS*REG_AW, per-slot destination.
REQ-009 SHALL have ports dst_we, is_load input NUM_SLOTS, per-slot write enable and load flag.
REQ-010 SHALL have port flush input 1, branch/jump/exception squash.
REQ-011 SHALL have port stall output 1, issue blocked this cycle; issue_ready = !stall.
REQ-012 SHALL have ports fwd_a_sel, fwd_b_sel output NUM_SLOTS*SW with SW = clog2(DEPTH*NUM_SLOTS+1), per-slot operand source.
REQ-013 SHALL have ports inflight output clog2(DEPTH*NUM_SLOTS+1), count of valid pending writes, and stall_count output 16, saturating stall-cycle count.
REQ-014 SHALL have port err_waw output 1, sticky same-bundle WAW flag.

Function
REQ-015 SHALL hold a DEPTH x NUM_SLOTS table of {valid, dst, is_load}; every edge stage k+1 <= stage k; entries leaving stage DEPTH-1 retire.
REQ-016 SHALL load stage 0 with the bundle (valid = issue_valid & dst_we) when issue_valid & !stall & !flush, else with all-invalid bubble.
REQ-017 SHALL on flush also invalidate current stage 0 contents at the edge; stages >= 1 are unaffected.
REQ-018 SHALL encode fwd sel as 0 = register file, 1 + k*NUM_SLOTS + s = stage k slot s.
REQ-019 SHALL match a source against valid entries only; register 0 is not special.
REQ-020 SHALL choose the youngest match (lowest k); within one stage the highest slot index wins.
REQ-021 SHALL not forward within a bundle: sources read pre-bundle values.
REQ-022 SHALL assert stall combinationally when issue_valid and any slot's selected match is a load in stage k < LOAD_READY; stall is 0 when issue_valid is 0.
REQ-023 SHALL give flush priority over stall: stall is forced 0 when flush = 1.
REQ-024 SHALL compute stall and fwd sels in the same cycle from inputs and registered state (zero latency).
REQ-025 SHALL increment stall_count on each stalled cycle, saturating at 0xFFFF.
REQ-026 SHALL set err_waw when an accepted bundle has two slots with dst_we and equal dst; clears only on reset.
REQ-027 SHALL drive inflight as the popcount of valid table entries.

Reset
REQ-028 SHALL on reset low clear all table valid bits, stall_count and err_waw immediately, independent of clk.
REQ-029 SHALL thereby drive stall = 0, all fwd sels = 0 and inflight = 0 while reset is low, including mid-operation.

Structure
REQ-030 SHALL place the sel-encoding function, SW width, and default parameter values in shared package vliw_pkg.
REQ-031 SHALL use one sub-module, sb_match, which is the per-operand priority matcher, instantiated 2*NUM_SLOTS times.

Verification (defaults)
REQ-032 SHALL cover: slot0 writes r3 (ALU), next cycle slot1 src_a=r3 -> fwd_a_sel[1]=1, stall=0.
REQ-033 SHALL cover: slot1 load to r5, next cycle slot0 src_b=r5 -> stall=1 one cycle, stall_count=1; following cycle fwd_b_sel[0]=4, stall=0.
REQ-034 SHALL cover: stage0 slot0 and stage1 slot1 both write r2, consumer reads r2 -> sel=1.
REQ-035 SHALL cover: bundle with both slots dst=r4 and dst_we=11 -> err_waw=1 sticky; next cycle read r4 -> sel=2.
REQ-036 SHALL cover: flush with a bundle writing r6 -> next cycle read r6 -> sel=0, inflight unchanged by that bundle.
REQ-037 SHALL cover: reset low with inflight=3 -> inflight=0, stall=0, sels=0 before the next clk edge.

Source files
------------

// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared defaults and forwarding-select helpers for the VLIW scoreboard
package vliw_pkg;

    localparam int DEF_NUM_SLOTS  = 2;
    localparam int DEF_REG_AW     = 3;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_READY = 1;

    // Width of one forwarding select: 0 means register file, then one code per table entry.
    function automatic int sel_width(input int depth, input int num_slots);
        return $clog2(depth * num_slots + 1);
    endfunction

    // Forwarding select code for the entry at a given stage and slot.
    function automatic int enc_sel(input int stage, input int slot, input int num_slots);
        return 1 + stage * num_slots + slot;
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - per-operand priority matcher against the in-flight write table
module sb_match
    import vliw_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int SW         = sel_width(DEF_DEPTH, DEF_NUM_SLOTS)
) (
    input  logic [REG_AW-1:0]                  src,
    input  logic [DEPTH*NUM_SLOTS-1:0]         tbl_valid,
    input  logic [DEPTH*NUM_SLOTS*REG_AW-1:0]  tbl_dst,
    input  logic [DEPTH*NUM_SLOTS-1:0]         tbl_load,
    output logic [SW-1:0]                      sel,
    output logic                               load_hazard
);

    // Scan oldest to youngest so the last hit (lowest stage, highest slot) wins.
    always_comb begin
        sel         = '0;
        load_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (tbl_valid[k*NUM_SLOTS+s] &&
                    tbl_dst[(k*NUM_SLOTS+s)*REG_AW +: REG_AW] == src) begin
                    sel         = SW'(enc_sel(k, s, NUM_SLOTS));
                    load_hazard = tbl_load[k*NUM_SLOTS+s] && (k < LOAD_READY);
                end
            end
        end
    end

endmodule

// File: rtl/vliw_scoreboard.sv
// rtl/vliw_scoreboard.sv - VLIW issue scoreboard with forwarding selects and load-use stall
module vliw_scoreboard
    import vliw_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    localparam int SW        = sel_width(DEPTH, NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [NUM_SLOTS*REG_AW-1:0] src_a,
    input  logic [NUM_SLOTS*REG_AW-1:0] src_b,
    input  logic [NUM_SLOTS*REG_AW-1:0] dst,
    input  logic [NUM_SLOTS-1:0]        dst_we,
    input  logic [NUM_SLOTS-1:0]        is_load,
    input  logic                        flush,
    output logic                        stall,
    output logic [NUM_SLOTS*SW-1:0]     fwd_a_sel,
    output logic [NUM_SLOTS*SW-1:0]     fwd_b_sel,
    output logic [SW-1:0]               inflight,
    output logic [15:0]                 stall_count,
    output logic                        err_waw
);

    localparam int N = DEPTH * NUM_SLOTS;

    // Table entry e = stage*NUM_SLOTS + slot; stage 0 is the youngest.
    logic [N-1:0]        tv;
    logic [N-1:0]        tl;
    logic [N*REG_AW-1:0] td;
    logic [2*NUM_SLOTS-1:0] hz;
    logic                accept;
    logic                waw;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        sb_match #(
            .NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .DEPTH(DEPTH),
            .LOAD_READY(LOAD_READY), .SW(SW)
        ) u_match_a (
            .src(src_a[s*REG_AW +: REG_AW]), .tbl_valid(tv), .tbl_dst(td), .tbl_load(tl),
            .sel(fwd_a_sel[s*SW +: SW]), .load_hazard(hz[2*s])
        );
        sb_match #(
            .NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .DEPTH(DEPTH),
            .LOAD_READY(LOAD_READY), .SW(SW)
        ) u_match_b (
            .src(src_b[s*REG_AW +: REG_AW]), .tbl_valid(tv), .tbl_dst(td), .tbl_load(tl),
            .sel(fwd_b_sel[s*SW +: SW]), .load_hazard(hz[2*s+1])
        );
    end

    // Flush overrides any load-use hazard; an accepted bundle is one neither stalled nor squashed.
    assign stall  = issue_valid & ~flush & (|hz);
    assign accept = issue_valid & ~stall & ~flush;

    // Detect two slots of the incoming bundle writing the same register.
    always_comb begin
        waw = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = i + 1; j < NUM_SLOTS; j++) begin
                if (dst_we[i] && dst_we[j] &&
                    dst[i*REG_AW +: REG_AW] == dst[j*REG_AW +: REG_AW]) begin
                    waw = 1'b1;
                end
            end
        end
    end

    // Count valid pending writes across the whole table.
    always_comb begin
        inflight = '0;
        for (int e = 0; e < N; e++) begin
            inflight = inflight + SW'(tv[e]);
        end
    end

    // Valid bits advance one stage per cycle; flush squashes the bundle leaving stage 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tv <= '0;
        end else begin
            tv[0 +: NUM_SLOTS] <= accept ? dst_we : '0;
            for (int k = 1; k < DEPTH; k++) begin
                tv[k*NUM_SLOTS +: NUM_SLOTS] <= (k == 1 && flush) ? '0
                                              : tv[(k-1)*NUM_SLOTS +: NUM_SLOTS];
            end
        end
    end

    // Destination and load flags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        td[0 +: NUM_SLOTS*REG_AW] <= dst;
        tl[0 +: NUM_SLOTS]        <= is_load;
        for (int k = 1; k < DEPTH; k++) begin
            td[k*NUM_SLOTS*REG_AW +: NUM_SLOTS*REG_AW] <= td[(k-1)*NUM_SLOTS*REG_AW +: NUM_SLOTS*REG_AW];
            tl[k*NUM_SLOTS +: NUM_SLOTS]               <= tl[(k-1)*NUM_SLOTS +: NUM_SLOTS];
        end
    end

    // Saturating stall counter and sticky same-bundle WAW flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            err_waw     <= 1'b0;
        end else begin
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (accept && waw) begin
                err_waw <= 1'b1;
            end
        end
    end

endmodule
